// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - Load/store unit: one outstanding data-memory access with lane steering and timeout.
module core_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [1:0]  ex_mem_op,
    input  logic [2:0]  ex_mem_size,
    input  logic [31:0] alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_stall,
    output logic        lsu_misalign,
    output logic        lsu_bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [4:0]  rd_q;
    logic [31:0] sdata_q;
    logic        we_q;
    logic [7:0]  wait_q;
    logic [31:0] ldata_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic        accept;
    logic        ex_misaligned;
    logic        in_req;
    logic        in_resp;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    // size[1:0] selects the width (00 byte, 01 half, else word); size[2] marks zero-extension.
    assign accept = (state == S_IDLE) && ex_valid && (ex_mem_op == 2'b01 || ex_mem_op == 2'b10);

    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_mem_size[1:0])
            2'b00:   ex_misaligned = 1'b0;
            2'b01:   ex_misaligned = alu_result[0];
            default: ex_misaligned = (alu_result[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        shifted  = dmem_rdata >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (size_q[1:0])
            2'b00:   load_ext = size_q[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = size_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = sdata_q;
        if (we_q) begin
            case (size_q[1:0])
                2'b00: begin
                    store_be    = 4'b0001 << addr_q[1:0];
                    store_wdata = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    store_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    store_be    = 4'b1111;
                    store_wdata = sdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= 32'd0;
            size_q     <= 3'd0;
            rd_q       <= 5'd0;
            sdata_q    <= 32'd0;
            we_q       <= 1'b0;
            wait_q     <= 8'd0;
            ldata_q    <= 32'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= alu_result;
                        size_q  <= ex_mem_size;
                        rd_q    <= ex_rd;
                        sdata_q <= ex_store_data;
                        we_q    <= (ex_mem_op == 2'b10);
                        wait_q  <= 8'd0;
                        if (ex_misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        if (we_q) begin
                            state <= S_IDLE;
                        end else begin
                            ldata_q <= load_ext;
                            state   <= S_RESP;
                        end
                    end else if (wait_q == 8'(TIMEOUT - 1)) begin
                        state     <= S_IDLE;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus and writeback outputs are gated by state so reset clears them without extra flops.
    assign in_req       = (state == S_REQ);
    assign in_resp      = (state == S_RESP);
    assign dmem_req     = in_req;
    assign dmem_we      = in_req & we_q;
    assign dmem_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be      = in_req ? store_be : 4'd0;
    assign dmem_wdata   = in_req ? store_wdata : 32'd0;
    assign wb_valid     = in_resp;
    assign wb_rd        = in_resp ? rd_q : 5'd0;
    assign wb_data      = in_resp ? ldata_q : 32'd0;
    assign lsu_stall    = (state != S_IDLE);
    assign lsu_misalign = misalign_q;
    assign lsu_bus_err  = bus_err_q;

endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles dmem_req is held without dmem_ack before abort, range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port ex_valid, input, 1: execute-stage op valid this cycle.
REQ-005 SHALL have port ex_mem_op, input, 2: 00 none, 01 load, 10 store, 11 treated as none.
REQ-006 SHALL have port ex_mem_size, input, 3: funct3; 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-007 SHALL have port alu_result, input, 32: effective address from the ALU.
REQ-008 SHALL have port ex_store_data, input, 32: rs2 value for stores.
REQ-009 SHALL have port ex_rd, input, 5: load destination register.
REQ-010 SHALL have ports dmem_req output 1, dmem_we output 1, dmem_addr output 32 (word-aligned), dmem_be output 4, dmem_wdata output 32.
REQ-011 SHALL have ports dmem_ack input 1 and dmem_rdata input 32; rdata is valid in the ack cycle.
REQ-012 SHALL have ports wb_valid output 1, wb_rd output 5, wb_data output 32.
REQ-013 SHALL have ports lsu_stall, lsu_misalign and lsu_bus_err, each output 1.

Function
REQ-014 SHALL implement FSM states IDLE, REQ and RESP.
REQ-015 SHALL accept an op when state=IDLE, ex_valid=1 and ex_mem_op is 01 or 10.
- Latches address, size, rd, store data and we.
REQ-016 SHALL flag misalignment when W has addr[1:0]!=0, or H/HU has addr[0]!=0.
- Pulses lsu_misalign one cycle after accept.
- Issues no request; stays IDLE.
REQ-017 SHALL, for an aligned accept, enter REQ the next cycle and hold dmem_req=1 until dmem_ack=1 is sampled.
- ack in the first REQ cycle is legal, giving a 1-cycle request.
REQ-018 SHALL keep dmem_addr, dmem_we, dmem_be and dmem_wdata stable while dmem_req=1; dmem_addr={addr[31:2],2'b00}.
REQ-019 SHALL drive store lanes as follows:
- SB: be=1<<addr[1:0], wdata={4{data[7:0]}}.
- SH: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
- SW: be=1111.
REQ-020 SHALL drive be=1111 for loads.
REQ-021 SHALL, on store ack, return to IDLE next cycle with no writeback.
REQ-022 SHALL, on load ack, shift rdata right by 8*addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU) into a register, then enter RESP.
REQ-023 SHALL, in RESP, assert wb_valid=1 for exactly one cycle with wb_rd and wb_data, then go to IDLE.
REQ-024 SHALL keep a wait counter in REQ, cleared on entry.
- If TIMEOUT cycles elapse with no ack: drop dmem_req, pulse lsu_bus_err one cycle, go to IDLE, no writeback.
REQ-025 SHALL have lsu_stall = (state!=IDLE), combinational.
- Ops presented while stalled are ignored; upstream holds them.
REQ-026 SHALL ignore dmem_ack outside REQ.
REQ-027 SHALL make load latency, accept to wb_valid, equal to 2 + (cycles waiting for ack).
- Minimum 2; back-to-back accept is possible the cycle after RESP.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: state IDLE, all dmem_* outputs 0, wb_valid 0, wb_rd 0, wb_data 0, lsu_stall 0, lsu_misalign 0, lsu_bus_err 0, wait counter 0.
REQ-029 SHALL abandon any in-flight op on reset mid-transaction and produce no writeback after release.
REQ-030 SHALL accept a new op in the first clock edge after rst_n rises.

Verification
REQ-031 SHALL be tested with: LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF, rd=5 -> dmem_addr 0x100, be 1111; wb_valid one cycle, rd 5, data 0xDEADBEEF.
REQ-032 SHALL be tested with: LB addr 0x103, rdata 0x80FF_0000 -> wb_data 0xFFFFFF80. LBU at the same address -> wb_data 0x00000080.
REQ-033 SHALL be tested with: SH addr 0x202, data 0x1234ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD, we 1, no wb_valid.
REQ-034 SHALL be tested with: LW addr 0x101 -> lsu_misalign pulses once, dmem_req stays 0, lsu_stall stays 0.
REQ-035 SHALL be tested with: TIMEOUT=4 and ack never arriving -> dmem_req high 4 cycles, lsu_bus_err one pulse, then IDLE.
REQ-036 SHALL be tested with: rst_n low during REQ -> dmem_req 0 asynchronously; late ack after release produces no wb_valid.
